// File: rtl/returns_pkg.sv
`default_nettype none
// ============================================================================
// Module : returns_pkg
// Brief  : Shared types and defaults for the price-return feeder.
// Rev    : 1.0
// ============================================================================
package returns_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_FRACT    = 8;
  localparam int DEF_N_STOCKS = 4;
  localparam int DIV_W        = DEF_WIDTH + DEF_FRACT;

  typedef logic        [DEF_WIDTH-1:0] price_t;
  typedef logic signed [DEF_WIDTH-1:0] ret_t;

  typedef enum logic [2:0] {
    PRIME = 3'd0,
    IDLE  = 3'd1,
    LOAD  = 3'd2,
    DIV   = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module : seq_divider
// Brief  : Unsigned restoring divider, one quotient bit per cycle, MSB first.
//          done marks the final step; quotient is final from the next cycle.
// Rev    : 1.0
// ============================================================================
module seq_divider #(
  parameter int DIV_W = returns_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic             div_zero
);

  localparam int                 c_cnt_w = (DIV_W > 1) ? $clog2(DIV_W) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV_W - 1);

  logic [DIV_W-1:0]   r_q;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   r_rem;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_dz;

  logic [DIV_W:0] w_shift;
  logic [DIV_W:0] w_sub;

  assign w_shift = {r_rem, r_q[DIV_W-1]};
  assign w_sub   = w_shift - {1'b0, r_div};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_dz   <= 1'b0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_div  <= divisor;
      r_dz   <= (divisor == '0);
      r_q    <= (divisor == '0) ? '0 : dividend;
    end else if (r_busy) begin
      // A zero divisor still burns the full step count so callers see fixed latency.
      if (!r_dz) begin
        if (w_sub[DIV_W]) begin
          r_rem <= w_shift[DIV_W-1:0];
          r_q   <= {r_q[DIV_W-2:0], 1'b0};
        end else begin
          r_rem <= w_sub[DIV_W-1:0];
          r_q   <= {r_q[DIV_W-2:0], 1'b1};
        end
      end
      r_cnt <= r_cnt + c_cnt_w'(1);
      if (r_cnt == c_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_busy && (r_cnt == c_last);
  assign quotient = r_q;
  assign div_zero = r_dz;

endmodule
`default_nettype wire

// File: rtl/returns_calc.sv
`default_nettype none
// ============================================================================
// Module : returns_calc
// Brief  : Per-stock simple return (p_t - p_{t-1}) / p_{t-1} via a shared
//          sequential divider. RETURNS_SAT_EN: clamp instead of wrap.
// Rev    : 1.0
// ============================================================================
module returns_calc
  import returns_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRACT    = DEF_FRACT,
  parameter int N_STOCKS = DEF_N_STOCKS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [N_STOCKS*WIDTH-1:0] price_in,
  output logic                      valid_out,
  output logic [N_STOCKS*WIDTH-1:0] ret_out,
  output logic [N_STOCKS-1:0]       div_zero
);

  localparam int                 c_div_w    = WIDTH + FRACT;
  localparam int                 c_idx_w    = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_STOCKS - 1);

  state_t              r_state;
  logic [c_idx_w-1:0]  r_idx;
  logic                r_neg;
  logic [WIDTH-1:0]    r_prev    [N_STOCKS];
  logic [WIDTH-1:0]    r_cur     [N_STOCKS];
  logic [WIDTH-1:0]    r_ret     [N_STOCKS];
  logic [WIDTH-1:0]    r_ret_out [N_STOCKS];
  logic [N_STOCKS-1:0] r_dz;
  logic [N_STOCKS-1:0] r_dz_out;
  logic                r_valid_out;

  logic [WIDTH-1:0]    w_price [N_STOCKS];
  logic [WIDTH:0]      w_diff;
  logic                w_neg;
  logic [WIDTH-1:0]    w_mag;
  logic [c_div_w-1:0]  w_dividend;
  logic [c_div_w-1:0]  w_divisor;
  logic [c_div_w-1:0]  w_q;
  logic                w_div_start;
  logic                w_div_busy;
  logic                w_div_done;
  logic                w_div_zero;
  logic [WIDTH-1:0]    w_wrap;
  logic [WIDTH-1:0]    w_ret;

  for (genvar i = 0; i < N_STOCKS; i++) begin : g_lane
    assign w_price[i]                = price_in[i*WIDTH +: WIDTH];
    assign ret_out[i*WIDTH +: WIDTH] = r_ret_out[i];
  end

  assign w_diff      = {1'b0, r_cur[r_idx]} - {1'b0, r_prev[r_idx]};
  assign w_neg       = w_diff[WIDTH];
  assign w_mag       = w_neg ? -w_diff[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_dividend  = {w_mag, {FRACT{1'b0}}};
  assign w_divisor   = {{FRACT{1'b0}}, r_prev[r_idx]};
  assign w_div_start = (r_state == LOAD);

  seq_divider #(
    .DIV_W (c_div_w)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend (w_dividend),
    .divisor  (w_divisor),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_q),
    .div_zero (w_div_zero)
  );

  // Truncation on the magnitude gives round-toward-zero once the sign is restored.
  assign w_wrap = r_neg ? -w_q[WIDTH-1:0] : w_q[WIDTH-1:0];

`ifdef RETURNS_SAT_EN
  localparam logic [c_div_w-1:0] c_pos_lim = c_div_w'((2 ** (WIDTH-1)) - 1);
  localparam logic [c_div_w-1:0] c_neg_lim = c_div_w'(2 ** (WIDTH-1));

  always_comb begin
    w_ret = w_wrap;
    if (!r_neg && (w_q > c_pos_lim)) begin
      w_ret = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (r_neg && (w_q > c_neg_lim)) begin
      w_ret = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  logic w_unused_q_hi;
  assign w_unused_q_hi = ^w_q[c_div_w-1:WIDTH];
  assign w_ret         = w_wrap;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PRIME;
      r_idx       <= '0;
      r_neg       <= 1'b0;
      r_prev      <= '{default: '0};
      r_cur       <= '{default: '0};
      r_ret       <= '{default: '0};
      r_ret_out   <= '{default: '0};
      r_dz        <= '0;
      r_dz_out    <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      case (r_state)
        PRIME: begin
          if (valid_in) begin
            r_prev  <= w_price;
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (valid_in) begin
            r_cur   <= w_price;
            r_idx   <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_neg   <= w_neg;
          r_state <= DIV;
        end
        DIV: begin
          // An idle divider here can only mean a lost start; never stall on it.
          if (w_div_done || !w_div_busy) begin
            r_state <= WB;
          end
        end
        WB: begin
          r_ret[r_idx] <= w_ret;
          r_dz[r_idx]  <= w_div_zero;
          if (r_idx == c_last_idx) begin
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + c_idx_w'(1);
            r_state <= LOAD;
          end
        end
        DONE: begin
          r_ret_out   <= r_ret;
          r_dz_out    <= r_dz;
          r_valid_out <= 1'b1;
          r_prev      <= r_cur;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= PRIME;
        end
      endcase
    end
  end

  assign ready_out = (r_state == PRIME) || (r_state == IDLE);
  assign valid_out = r_valid_out;
  assign div_zero  = r_dz_out;

endmodule
`default_nettype wire

// File: tb/tb_returns_calc.sv
`default_nettype none
// ============================================================================
// Module : tb_returns_calc
// Brief  : Directed vector table plus back-pressure and async-reset sequences.
// Rev    : 1.0
// ============================================================================
module tb_returns_calc;
  import returns_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [63:0] price_in;
  logic        valid_out;
  logic [63:0] ret_out;
  logic [3:0]  div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  returns_calc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .price_in  (price_in),
    .valid_out (valid_out),
    .ret_out   (ret_out),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] price;
    logic [63:0] exp_ret;
    logic [3:0]  exp_dz;
    bit          prime;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic price_t ref_ret(input price_t p, input price_t c);
    longint num;
    longint q;
    if (p == 0) return '0;
    num = (longint'(c) - longint'(p)) * 256;
    q   = num / longint'(p);
`ifdef RETURNS_SAT_EN
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
`endif
    return q[15:0];
  endfunction

  function automatic logic [63:0] ref_vec(input logic [63:0] p, input logic [63:0] c);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = ref_ret(p[i*16 +: 16], c[i*16 +: 16]);
    return r;
  endfunction

  function automatic logic [3:0] ref_dz(input logic [63:0] p);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) d[i] = (p[i*16 +: 16] == 16'h0000);
    return d;
  endfunction

  function automatic logic [63:0] bp_price(input int k);
    logic [63:0] p;
    for (int i = 0; i < 4; i++) p[i*16 +: 16] = 16'(32'h100 + k + i * 64);
    return p;
  endfunction

  task automatic send(input logic [63:0] p);
    int guard;
    guard = 0;
    while (!ready_out && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_send", {63'd0, ready_out}, 64'd1);
    valid_in = 1'b1;
    price_in = p;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_out(input int bound, output int lat);
    lat = 0;
    while (!valid_out && lat < bound) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  logic [15:0] ovf_val;
  logic [63:0] prev_snap;
  logic [63:0] p_a, p_b, p_c;
  int          lat;
  logic        exp_rdy, exp_vld;

  initial begin
`ifdef RETURNS_SAT_EN
    ovf_val = 16'h7FFF;
`else
    ovf_val = 16'hFE00;
`endif
    tbl[0] = '{price: {4{16'h6400}}, exp_ret: 64'h0, exp_dz: 4'h0, prime: 1'b1};
    tbl[1] = '{price: {4{16'h6500}}, exp_ret: {4{16'h0002}}, exp_dz: 4'h0, prime: 1'b0};
    tbl[2] = '{price: {16'h0080, 16'h0200, 16'h0100, 16'h6400},
               exp_ret: {16'hFF02, 16'hFF06, 16'hFF03, 16'hFFFE}, exp_dz: 4'h0, prime: 1'b0};
    tbl[3] = '{price: {16'h0080, 16'h0100, 16'h0200, 16'h6300},
               exp_ret: {16'h0000, 16'hFF80, 16'h0100, 16'hFFFE}, exp_dz: 4'h0, prime: 1'b0};
    tbl[4] = '{price: {16'h0100, 16'h0000, 16'h0080, 16'h0001},
               exp_ret: {16'h0100, 16'hFF00, 16'hFF40, 16'hFF01}, exp_dz: 4'h0, prime: 1'b0};
    tbl[5] = '{price: {16'h0200, 16'h1234, 16'h0080, 16'hFFFF},
               exp_ret: {16'h0100, 16'h0000, 16'h0000, ovf_val}, exp_dz: 4'b0100, prime: 1'b0};
    tbl[6] = '{price: {16'h0200, 16'h0001, 16'h0040, 16'h0000},
               exp_ret: {16'h0000, 16'hFF01, 16'hFF80, 16'hFF00}, exp_dz: 4'h0, prime: 1'b0};

    rst_n    = 1'b0;
    valid_in = 1'b0;
    price_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_out", {63'd0, valid_out}, 64'd0);
    chk("reset_ret_out",   ret_out, 64'd0);
    chk("reset_div_zero",  {60'd0, div_zero}, 64'd0);
    chk("reset_ready_out", {63'd0, ready_out}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      send(tbl[v].price);
      if (tbl[v].prime) begin
        wait_out(120, lat);
        chk($sformatf("vec%0d_prime_no_output", v), 64'(lat), 64'd120);
        chk($sformatf("vec%0d_prime_ret", v), ret_out, 64'd0);
      end else begin
        wait_out(200, lat);
        chk($sformatf("vec%0d_latency", v), 64'(lat), 64'd105);
        chk($sformatf("vec%0d_ret", v), ret_out, tbl[v].exp_ret);
        chk($sformatf("vec%0d_dz", v), {60'd0, div_zero}, {60'd0, tbl[v].exp_dz});
        @(posedge clk); #1;
        chk($sformatf("vec%0d_pulse_width", v), {63'd0, valid_out}, 64'd0);
        chk($sformatf("vec%0d_ret_held", v), ret_out, tbl[v].exp_ret);
      end
    end

    // valid_in held high: only snapshots 0 and 106 may be taken.
    prev_snap = tbl[6].price;
    valid_in  = 1'b1;
    for (int k = 0; k <= 212; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      price_in = bp_price(k);
      exp_rdy  = (k == 0) || (k == 106) || (k == 212);
      exp_vld  = (k == 106) || (k == 212);
      chk($sformatf("bp_ready_k%0d", k), {63'd0, ready_out}, {63'd0, exp_rdy});
      chk($sformatf("bp_valid_k%0d", k), {63'd0, valid_out}, {63'd0, exp_vld});
      if (k == 106) begin
        chk("bp_ret_first", ret_out, ref_vec(prev_snap, bp_price(0)));
        chk("bp_dz_first", {60'd0, div_zero}, {60'd0, ref_dz(prev_snap)});
      end
      if (k == 212) begin
        chk("bp_ret_second", ret_out, ref_vec(bp_price(0), bp_price(106)));
        chk("bp_dz_second", {60'd0, div_zero}, 64'd0);
      end
    end
    valid_in = 1'b0;

    // Async reset in the middle of a division.
    p_a = {4{16'h0300}};
    p_b = {16'h0400, 16'h0000, 16'h0300, 16'h0200};
    p_c = {16'h0400, 16'h0050, 16'h0100, 16'h0300};
    send(p_a);
    repeat (50) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid_out", {63'd0, valid_out}, 64'd0);
    chk("midreset_ret_out",   ret_out, 64'd0);
    chk("midreset_div_zero",  {60'd0, div_zero}, 64'd0);
    chk("midreset_ready_out", {63'd0, ready_out}, 64'd1);
    @(posedge clk); #1;
    chk("midreset_held_ret", ret_out, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(p_b);
    wait_out(120, lat);
    chk("reprime_no_output", 64'(lat), 64'd120);
    send(p_c);
    wait_out(200, lat);
    chk("after_reset_latency", 64'(lat), 64'd105);
    chk("after_reset_ret", ret_out, ref_vec(p_b, p_c));
    chk("after_reset_dz", {60'd0, div_zero}, {60'd0, ref_dz(p_b)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
